mvm_operand_loader: RTL

MVM_OPERAND_LOADER -- requirements
Module: mvm_operand_loader

---
 rtl/mvm_operand_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/mvm_operand_loader.sv
// Operand loader for the 2x2 matrix-vector multiplier: packs three input bytes into one matrix/vector frame.
// Optional delivered-frame counter enabled by defining MVM_LOADER_FRAME_CNT_EN.
module mvm_operand_loader #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*DATA_W-1:0] matrix,
  output logic [DATA_W-1:0]   vector,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [1:0] {
    S_ROW0 = 2'd0,
    S_ROW1 = 2'd1,
    S_VEC  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] stage_row0;
  logic [DATA_W-1:0] stage_row1;
  logic [DATA_W-1:0] stage_vec;
  logic              slot_free;
  logic              accept;
  logic              load_out;
  logic              consume;

  assign in_ready  = (state != S_HOLD);
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ROW0;
    else     state <= state_next;
  end

  // Frame sequencing; flush overrides every handshake decision.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    case (state)
      S_ROW0: if (accept) state_next = S_ROW1;
      S_ROW1: if (accept) state_next = S_VEC;
      S_VEC: begin
        if (accept) begin
          state_next = slot_free ? S_ROW0 : S_HOLD;
          load_out   = slot_free;
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          state_next = S_ROW0;
          load_out   = 1'b1;
        end
      end
      default: state_next = S_ROW0;
    endcase
    if (flush) begin
      state_next = S_ROW0;
      load_out   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_row0 <= '0;
      stage_row1 <= '0;
      stage_vec  <= '0;
    end else if (flush) begin
      stage_row0 <= '0;
      stage_row1 <= '0;
      stage_vec  <= '0;
    end else if (accept) begin
      case (state)
        S_ROW0:  stage_row0 <= in_data;
        S_ROW1:  stage_row1 <= in_data;
        S_VEC:   stage_vec  <= in_data;
        default: stage_vec  <= stage_vec;
      endcase
    end
  end

  // A direct load from S_VEC takes the last byte straight off the input bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix    <= '0;
      vector    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_out) begin
        matrix <= {stage_row1, stage_row0};
        vector <= (state == S_HOLD) ? stage_vec : in_data;
      end
      if (flush)         out_valid <= 1'b0;
      else if (load_out) out_valid <= 1'b1;
      else if (consume)  out_valid <= 1'b0;
    end
  end

`ifdef MVM_LOADER_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_cnt <= 8'h00;
    else if (consume) frame_cnt <= frame_cnt + 8'h01;
  end
`else
  assign frame_cnt = 8'h00;
`endif

endmodule
